// File: rtl/multdiv_stall_ctrl.sv
// multdiv_stall_ctrl: sequencer for the shared iterative multiply/divide unit.
// Catches a mul/div in DX and stalls PC/FD/DX while it runs one bit per cycle.
// The result is then handed to XM as a one-cycle pulse.
// Optional build macro MULTDIV_EARLY_OUT_EN: a zero operand skips RUN entirely.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a valid mul/div in DX; start stalls combinationally
// RUN   | one multiply/divide iteration per cycle, pipeline frozen
// DONE  | result_valid pulse; stall released so DX retires the op into XM
module multdiv_stall_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dx_valid,
    input  logic [4:0]       dx_opcode,
    input  logic [4:0]       dx_aluop,
    input  logic [4:0]       dx_rd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_rd,
    output logic             result_exc
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             neg_q;
    logic             dz_q;
    logic             ovf_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       result_rd_q;
    logic             result_exc_q;

    logic             is_mul, is_div, start;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             early_out, early_exc;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_n, div_lo_n;
    logic [WIDTH-1:0]   hi_n, lo_n;
    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic [WIDTH-1:0]   mul_res, div_res, quo_s;
    logic               mul_exc, div_exc;

    // Decode and operand magnitudes; start is held off during reset so stall reads 0.
    always_comb begin
        is_mul = (dx_opcode == 5'b00000) && (dx_aluop == 5'b00110);
        is_div = (dx_opcode == 5'b00000) && (dx_aluop == 5'b00111);
        start  = !reset && dx_valid && (is_mul || is_div) && (state_q == IDLE);
        a_mag  = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
        b_mag  = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
    end

`ifdef MULTDIV_EARLY_OUT_EN
    // Any zero operand gives a zero result; only divide-by-zero flags an exception.
    always_comb begin
        early_out = start && ((op_a == '0) || (op_b == '0));
        early_exc = is_div && (op_b == '0);
    end
`else
    // Every operation takes the full iteration path.
    always_comb begin
        early_out = 1'b0;
        early_exc = 1'b0;
    end
`endif

    // One iteration of the shift-add multiply and the restoring divide on magnitudes.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opd_q : '0)};
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd_q});
        div_hi_n  = div_ge ? WIDTH'(div_shift - {1'b0, opd_q}) : div_shift[WIDTH-1:0];
        div_lo_n  = {lo_q[WIDTH-2:0], div_ge};
        hi_n      = div_q ? div_hi_n : mul_hi_n;
        lo_n      = div_q ? div_lo_n : mul_lo_n;
    end

    // Sign fix-up and exception flags, taken from the final iteration's outputs.
    always_comb begin
        prod_mag = {mul_hi_n, mul_lo_n};
        prod_s   = neg_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
        mul_res  = prod_s[WIDTH-1:0];
        mul_exc  = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        quo_s    = neg_q ? (~div_lo_n + WIDTH'(1)) : div_lo_n;
        div_res  = dz_q ? '0 : quo_s;
        div_exc  = dz_q || ovf_q;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = early_out ? DONE : RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, operand capture, iteration datapath and result latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= 1'b0;
            neg_q        <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            rd_q         <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            opd_q        <= '0;
            result_q     <= '0;
            result_rd_q  <= '0;
            result_exc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_q  <= dx_rd;
                        div_q <= is_div;
                        neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        dz_q  <= (op_b == '0);
                        ovf_q <= (op_a == MIN_NEG) && (op_b == '1);
                        hi_q  <= '0;
                        lo_q  <= is_div ? a_mag : b_mag;
                        opd_q <= is_div ? b_mag : a_mag;
                        cnt_q <= '0;
                        if (early_out) begin
                            result_q     <= '0;
                            result_rd_q  <= dx_rd;
                            result_exc_q <= early_exc;
                        end
                    end
                end
                RUN: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q     <= div_q ? div_res : mul_res;
                        result_rd_q  <= rd_q;
                        result_exc_q <= div_q ? div_exc : mul_exc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: stall covers the start cycle combinationally plus every RUN cycle.
    always_comb begin
        stall        = start || (state_q == RUN);
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE);
        result       = result_q;
        result_rd    = result_rd_q;
        result_exc   = result_exc_q;
    end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Bench for multdiv_stall_ctrl: expected hand-offs queued at issue, checked on each pulse.
module tb_multdiv_stall_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dx_valid = 1'b0;
    logic [4:0]  dx_opcode = '0;
    logic [4:0]  dx_aluop = '0;
    logic [4:0]  dx_rd = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall, busy, result_valid, result_exc;
    logic [31:0] result;
    logic [4:0]  result_rd;

    int total = 0;
    int bad = 0;

`ifdef MULTDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] r;
        logic [4:0]  rd;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    multdiv_stall_ctrl #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .dx_valid(dx_valid), .dx_opcode(dx_opcode),
        .dx_aluop(dx_aluop), .dx_rd(dx_rd), .op_a(op_a), .op_b(op_b),
        .stall(stall), .busy(busy), .result_valid(result_valid), .result(result),
        .result_rd(result_rd), .result_exc(result_exc)
    );

    always #5 clock = ~clock;

    // Every result_valid cycle must match the oldest queued expectation.
    always @(negedge clock) begin
        if (result_valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got result=%h rd=%0d exc=%b, required no pulse",
                         result, result_rd, result_exc);
            end else begin
                mon_x = sb_q.pop_front();
                if ({result, result_rd, result_exc} !== {mon_x.r, mon_x.rd, mon_x.e}) begin
                    bad++;
                    $display("FAIL result_check: got result=%h rd=%0d exc=%b, required result=%h rd=%0d exc=%b",
                             result, result_rd, result_exc, mon_x.r, mon_x.rd, mon_x.e);
                end
            end
        end
    end

    function automatic int exp_stall(input logic [31:0] a, input logic [31:0] b);
        return (EARLY && (a == 32'd0 || b == 32'd0)) ? 1 : 33;
    endfunction

    function automatic void model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (!div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p[63:32] != {32{p[31]}});
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    // Present one mul/div in DX, hold it while stalled, then retire it at DONE.
    task automatic issue(input bit div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] er, input logic ee,
                         input bit b2b, input string name);
        int n;
        int es;
        dx_valid  = 1'b1;
        dx_opcode = 5'd0;
        dx_aluop  = div ? 5'd7 : 5'd6;
        dx_rd     = rd;
        op_a      = a;
        op_b      = b;
        sb_q.push_back('{er, rd, ee});
        es = exp_stall(a, b);
        if (b2b) @(negedge clock);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
            if (stall === 1'b1) begin
                op_a  = $urandom;
                op_b  = $urandom;
                dx_rd = 5'($urandom);
            end
        end
        total++;
        if (n != es) begin
            bad++;
            $display("FAIL %s_stall_cycles: got %0d, required %0d", name, n, es);
        end
        dx_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++;
        if ({stall, busy, result_valid, result, result_rd, result_exc} !== 40'd0) begin
            bad++;
            $display("FAIL reset_state: got stall=%b busy=%b rv=%b result=%h rd=%0d exc=%b, required all 0",
                     stall, busy, result_valid, result, result_rd, result_exc);
        end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        @(negedge clock); issue(0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 0, "mul_7xm3");
        @(negedge clock); issue(0, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0, 1'b1, 0, "mul_ovf");
        @(negedge clock); issue(0, 32'h7FFF_FFFF, 32'd2, 5'd1, 32'hFFFF_FFFE, 1'b1, 0, "mul_maxx2");
        @(negedge clock); issue(0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'd31, 32'd30, 1'b0, 0, "mul_negneg");
        @(negedge clock); issue(0, 32'd0, 32'h1234, 5'd2, 32'd0, 1'b0, 0, "mul_zero");
    endtask

    task automatic test_div();
        @(negedge clock); issue(1, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0, 0, "div_m7d2");
        @(negedge clock); issue(1, 32'd100, 32'hFFFF_FFF9, 5'd4, 32'hFFFF_FFF2, 1'b0, 0, "div_100dm7");
        @(negedge clock); issue(1, 32'd5, 32'd0, 5'd6, 32'd0, 1'b1, 0, "div_by_zero");
        @(negedge clock); issue(1, 32'd0, 32'd9, 5'd7, 32'd0, 1'b0, 0, "div_zero_num");
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1'b1, 0, "div_ovf");
        issue(0, 32'd3, 32'd4, 5'd10, 32'd12, 1'b0, 1, "b2b_mul");
    endtask

    task automatic test_no_start();
        @(negedge clock);
        dx_valid = 1'b0; dx_opcode = 5'd0; dx_aluop = 5'd6; op_a = 32'd3; op_b = 32'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (stall !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL no_valid_start: got stall=%b busy=%b, required 0 0", stall, busy);
            end
            @(negedge clock);
        end
        dx_valid = 1'b1; dx_aluop = 5'd0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL non_muldiv_start: got stall=%b, required 0", stall);
        end
        @(negedge clock);
        dx_opcode = 5'd5; dx_aluop = 5'd6;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL opcode_nonzero_start: got stall=%b, required 0", stall);
        end
        @(negedge clock);
        dx_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clock);
        dx_valid = 1'b1; dx_opcode = 5'd0; dx_aluop = 5'd6; dx_rd = 5'd12;
        op_a = 32'd9; op_b = 32'd9;
        repeat (11) @(negedge clock);
        total++;
        if (stall !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_running: got stall=%b busy=%b, required 1 1", stall, busy);
        end
        reset = 1'b1;
        dx_valid = 1'b0;
        @(negedge clock);
        total++;
        if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_cleared: got stall=%b busy=%b rv=%b, required 0 0 0",
                     stall, busy, result_valid);
        end
        reset = 1'b0;
        repeat (40) @(negedge clock);
        total++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got stall=%b busy=%b, required 0 0", stall, busy);
        end
        issue(0, 32'd2, 32'd2, 5'd13, 32'd4, 1'b0, 0, "mul_after_abort");
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic        e;
        bit          div;
        for (int i = 0; i < 6; i++) begin
            a   = $urandom;
            b   = (i == 5) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            div = i[0];
            model(div, a, b, r, e);
            @(negedge clock);
            issue(div, a, b, 5'(i + 20), r, e, 0, "random");
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_no_start();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clock);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d results outstanding, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
